// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner of a shared 2-to-4 enable decoder; drives sel/en and mirrors a one-hot gnt.
// Latency: 1 cycle request-to-grant from IDLE; every hand-over inserts a one-cycle en=0 gap.
// Backpressure: none; an owner holds while it requests. Optional hold cap via `ARB_HOLD_LIMIT_EN.
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] win;
    logic       en_nxt;
    logic [3:0] gnt_nxt;
    logic       busy_nxt;
    logic       hold_hit;

    // Search last+1, last+2, last+3, last; the lowest offset with a request wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt;

    // Zero outside GRANT so the first grant cycle counts as 0; saturates at MAX_HOLD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state != GRANT) begin
            hold_cnt <= 8'd0;
        end else if (hold_cnt != 8'(MAX_HOLD - 1)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    always_comb begin
        hold_hit = (hold_cnt == 8'(MAX_HOLD - 1)) && ((req & ~(4'b0001 << sel)) != 4'b0000);
    end
`else
    always_comb begin
        hold_hit = 1'b0;
    end
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        en_nxt    = en;
        last_nxt  = last;
        win       = rr_pick(req, last);
        case (state)
            IDLE, GAP: begin
                if (req != 4'b0000) begin
                    state_nxt = GRANT;
                    sel_nxt   = win;
                    en_nxt    = 1'b1;
                    last_nxt  = win;
                end else begin
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel] || hold_hit) begin
                    state_nxt = GAP;
                    en_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
            end
        endcase
        gnt_nxt  = en_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
        busy_nxt = (state_nxt != IDLE);
    end

    // sel, en and gnt all load from the same next-state values so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 2'b11;
            sel   <= 2'b00;
            en    <= 1'b0;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            sel   <= sel_nxt;
            en    <= en_nxt;
            gnt   <= gnt_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with MAX_HOLD=4; hold-limit checks follow `ARB_HOLD_LIMIT_EN.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    rr_decoder_arbiter #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .sel  (sel),
        .en   (en),
        .gnt  (gnt),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic e, input logic b);
        check({tag, ".gnt"},  8'(gnt),  8'(g));
        check({tag, ".sel"},  8'(sel),  8'(s));
        check({tag, ".en"},   8'(en),   8'(e));
        check({tag, ".busy"}, 8'(busy), 8'(b));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] exp_g;

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check_all("rst_t0", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        check_all("rst_e1", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick();
        check_all("rst_e2", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("rst_rel", 4'b0001, 2'b00, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        check_all("rst_gap", 4'b0000, 2'b00, 1'b0, 1'b1);
        tick();
        check("rst_idle.busy", 8'(busy), 8'd0);

        // Single requester held five cycles, then released through GAP to IDLE.
        req = 4'b0100;
        tick();
        check_all("single", 4'b0100, 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_hold.gnt", 8'(gnt), 8'h04);
        end
        req = 4'b0000;
        tick();
        check_all("single_gap", 4'b0000, 2'b10, 1'b0, 1'b1);
        tick();
        check_all("single_idle", 4'b0000, 2'b10, 1'b0, 1'b0);

        // Rotation from a fresh pointer: 0,1,2,3,0 with one dead cycle between owners.
        pulse_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            check("rot_c1.gnt", 8'(gnt), 8'(exp_g));
            tick();
            check("rot_c2.gnt", 8'(gnt), 8'(exp_g));
            tick();
            check("rot_c3.gnt", 8'(gnt), 8'(exp_g));
            req = 4'b1111 & ~exp_g;
            tick();
            check("rot_gap.gnt", 8'(gnt), 8'h00);
            check("rot_gap.en", 8'(en), 8'h00);
            req = 4'b1111;
            tick();
        end
        check_all("rot_next", 4'b0010, 2'b01, 1'b1, 1'b1);

        // Owner 1 releases; pointer skips to 3, then wraps to 0.
        req = 4'b1001;
        tick();
        check("prio_gap1.gnt", 8'(gnt), 8'h00);
        req = 4'b1011;
        tick();
        check_all("prio_3", 4'b1000, 2'b11, 1'b1, 1'b1);
        req = 4'b0011;
        tick();
        check("prio_gap2.gnt", 8'(gnt), 8'h00);
        tick();
        check_all("prio_0", 4'b0001, 2'b00, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset between edges revokes the grant at once.
        req = 4'b0100;
        tick();
        check("async_pre.gnt", 8'(gnt), 8'h04);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        req = 4'b1111;
        tick();
        check_all("async_after", 4'b0001, 2'b00, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // Hold behaviour with two constant requesters.
        pulse_reset();
        req = 4'b0011;
`ifdef ARB_HOLD_LIMIT_EN
        for (int r = 0; r < 3; r++) begin
            exp_g = (r % 2 == 0) ? 4'b0001 : 4'b0010;
            for (int c = 0; c < 4; c++) begin
                tick();
                check("hold_own.gnt", 8'(gnt), 8'(exp_g));
            end
            tick();
            check("hold_gap.gnt", 8'(gnt), 8'h00);
        end
        tick();
        check("hold_wrap.gnt", 8'(gnt), 8'h02);
        req = 4'b0000;
        tick();
        tick();
        pulse_reset();
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            tick();
            check("hold_sat.gnt", 8'(gnt), 8'h01);
        end
`else
        for (int c = 0; c < 12; c++) begin
            tick();
            check("hold_none.gnt", 8'(gnt), 8'h01);
        end
`endif
        req = 4'b0000;
        tick();
        check("final_gap.gnt", 8'(gnt), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Round-robin arbiter that shares one 2-to-4 enable decoder between four requesters. It drives the decoder's 2-bit address and enable, and it mirrors the resulting one-hot grant. Ownership is held while the owner keeps requesting, and every hand-over includes a one-cycle dead gap. The block sits directly in front of the decoder and is the only source of its `A`/`EN` inputs.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when the hold limit is compiled in. Legal range is 2..255.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Reset is asynchronous and active-high.
- `req`: input, 4 bits. Request lines; bit i is requester i.
- `sel`: output, 2 bits. Decoder address (owner index).
- `en`: output, 1 bit. Decoder enable; high only while a grant is active.
- `gnt`: output, 4 bits. One-hot grant. It equals `1 << sel` when `en` is high and `4'b0000` otherwise.
- `busy`: output, 1 bit. High in the GRANT and GAP states.

## Operation
- FSM states: IDLE, GRANT, GAP. All outputs are registered.
- `last`: internal 2-bit pointer holding the index of the most recent owner.
- **Arbitration** is evaluated in IDLE and GAP on the sampled `req`:
  - Search order is `last+1, last+2, last+3, last`, modulo 4.
  - The first set bit in that order wins.
  - Consequence: the previous owner has lowest priority.
- **IDLE**:
  - `req==0`: stay in IDLE.
  - Otherwise: go to GRANT. `sel` takes the winner, `en` goes to 1, and `last` takes the winner.
- **GRANT**:
  - `req[sel]==1`: stay in GRANT. `sel` and `en` are unchanged.
  - `req[sel]==0`: go to GAP with `en` set to 0. `sel` keeps its value.
- **GAP**: lasts exactly one cycle, with `en=0`.
  - If any `req` is set, arbitrate and go to GRANT. Re-granting the same requester is allowed if it is the only one requesting.
  - Otherwise go to IDLE.
- **Simultaneous events**:
  - Owner drops its request while others rise in the same cycle: normal GAP path, then the rotating winner.
  - Requests arriving during GAP are considered at the end of GAP.
- **Reset value** of all outputs and state:
  - `sel=2'b00`, `en=0`, `gnt=4'b0000`, `busy=0`.
  - state=IDLE, `last=2'b11`, so requester 0 has first priority.
- **Reset mid-operation**: asserting `rst` clears everything immediately, without waiting for `clk`. The in-flight grant is revoked the same instant.

## Timing
- **Request-to-grant latency** from IDLE is 1 cycle. With `req` sampled high at edge N, `gnt` and `en` are valid after edge N.
- **Release**: `req[owner]` sampled low at edge N gives `en=0` after edge N. The GAP cycle follows, so the earliest new grant is valid after edge N+1.
- **Break-before-make**: `en` is low for at least 1 full cycle between any two owners. `gnt` never has more than one bit set.
- `gnt`, `sel` and `en` are mutually consistent in every cycle. All three are from the same register set, with no combinational path from `req`.

## Configuration
- **Macro**: `ARB_HOLD_LIMIT_EN`.
- **Defined**:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter equals `MAX_HOLD-1`, `req[sel]` is still high, and any other `req` bit is high, the FSM is forced to GAP. The owner therefore gets exactly `MAX_HOLD` grant cycles.
  - If no other requester is waiting, the counter saturates at `MAX_HOLD-1` and the grant continues.
- **Undefined**: the counter is absent. An owner holds indefinitely while its `req` stays high.

## Test plan
- **Reset**: drive `rst=1` with `req=4'b1111` → `en=0`, `gnt=0000`, `sel=00`, `busy=0` throughout. Release `rst` → `gnt=0001` one cycle later.
- **Single requester**: `req=0100` → after 1 edge, `gnt=0100`, `sel=10`, `en=1`, held for 5 cycles. Drop `req` → `gnt=0000` for one GAP cycle, then IDLE with `busy=0`.
- **Rotation**: `req=1111`; each owner drops and reasserts its request after 3 cycles → grant sequence `0001, 0010, 0100, 1000, 0001`, with exactly one `gnt=0000` cycle between each.
- **Priority pointer**: after owner 1 releases, apply `req=1011` → next grant is `1000`. Release, keep `req=0011` → next grant is `0001`.
- **Hold limit, `MAX_HOLD=4`, macro defined**: `req=0011` constant → `gnt=0001` for 4 cycles, `0000` for 1 cycle, `0010` for 4 cycles, and repeating. With the macro undefined, `gnt=0001` forever. With the macro defined and `req=0001` only, `gnt=0001` continues past 4 cycles.
- **Async reset mid-grant**: pulse `rst` between clock edges while `gnt=0100` → `gnt=0000` and `en=0` immediately. After release, `req=1111` → `gnt=0001`.
